// File: rtl/main_fsm.sv
// Auto-tune control FSM: captures an FFT frame, finds the dominant note, snaps it to
// the enabled scale and writes a pitch-shifted, conjugate-symmetric spectrum for the IFFT.
module main_fsm #(
   parameter int FS      = 48000,
   parameter int N       = 512,
   parameter int MIN_MAG = 64
) (
   input  logic        clk,
   input  logic        reset,
   output logic        done,
   output logic        note_done,
   output logic [3:0]  note_name,
   output logic [2:0]  note_octave,
   input  logic [11:0] scale,
   input  logic        fft_done,
   input  logic [8:0]  fft_address,
   input  logic        fft_read_valid,
   input  logic [35:0] fft_data,
   input  logic [8:0]  result_address,
   input  logic        result_read_enable,
   output logic [35:0] result_data,
   output logic        result_read_valid
);

   typedef enum logic [1:0] {COLLECT, DETECT, SNAP, BUILD} state_t;

   // Packed {octave[2:0], name[3:0]} per bin; bin 0 has no defined pitch.
   function automatic logic [1791:0] build_note_rom();
      logic [1791:0] rom;
      real f;
      int m, oct;
      rom = '0;
      for (int b = 0; b < 256; b++) begin
         if (b == 0) begin
            rom[b*7 +: 7] = {3'd0, 4'd15};
         end else begin
            f   = real'(b) * real'(FS) / real'(N);
            m   = $rtoi(69.0 + 12.0 * $ln(f / 440.0) / $ln(2.0) + 0.5);
            oct = m / 12 - 1;
            if (oct < 0) oct = 0;
            if (oct > 7) oct = 7;
            rom[b*7 +: 7] = {3'(oct), 4'(m % 12)};
         end
      end
      return rom;
   endfunction

   localparam logic [1791:0] NOTE_ROM = build_note_rom();

   // round(4096 * 2^(-s/12))
   function automatic logic [12:0] ratio(input logic signed [3:0] s);
      case (int'(s))
         -6:      return 13'd5793;
         -5:      return 13'd5468;
         -4:      return 13'd5161;
         -3:      return 13'd4871;
         -2:      return 13'd4598;
         -1:      return 13'd4340;
         1:       return 13'd3866;
         2:       return 13'd3649;
         3:       return 13'd3444;
         4:       return 13'd3251;
         5:       return 13'd3069;
         6:       return 13'd2896;
         default: return 13'd4096;
      endcase
   endfunction

   state_t             state, state_next;
   logic [35:0]        in_ram  [N];
   logic [35:0]        res_ram [N];
   logic [18:0]        peak_mag;
   logic [7:0]         peak_bin;
   logic signed [3:0]  shift, shift_calc;
   logic [9:0]         k;
   logic               s1_vld, s1_mirror, s1_zero;
   logic [8:0]         s1_k;
   logic [35:0]        rd_data, wdata;
   logic [17:0]        abs_re, abs_im, neg_im;
   logic [18:0]        mag;
   logic               collect_we, peak_upd, found, issue, mirror, zero, build_last;
   logic [3:0]         dn, up;
   logic [8:0]         kb, j, src;
   logic [9:0]         src_full;
   logic [6:0]         rom_entry;

   assign abs_re     = fft_data[35] ? -fft_data[35:18] : fft_data[35:18];
   assign abs_im     = fft_data[17] ? -fft_data[17:0]  : fft_data[17:0];
   assign mag        = {1'b0, abs_re} + {1'b0, abs_im};
   assign collect_we = (state == COLLECT) && fft_read_valid;
   assign peak_upd   = collect_we && !fft_address[8] && (fft_address[7:0] != 8'd0) && (mag > peak_mag);
   assign rom_entry  = NOTE_ROM[{3'b0, peak_bin} * 11'd7 +: 7];

   // Nearest enabled note, searching outward; the downward candidate is tested first so ties go down.
   always_comb begin
      shift_calc = '0;
      found      = 1'b0;
      dn         = '0;
      up         = '0;
      if (note_name < 4'd12) begin
         for (int d = 0; d <= 6; d++) begin
            dn = 4'((int'(note_name) + 12 - d) % 12);
            up = 4'((int'(note_name) + d) % 12);
            if (!found && scale[dn]) begin
               found      = 1'b1;
               shift_calc = 4'(-d);
            end else if (!found && scale[up]) begin
               found      = 1'b1;
               shift_calc = 4'(d);
            end
         end
      end
   end

   // Upper half recomputes its mirror bin instead of buffering the lower half.
   always_comb begin
      issue    = (state == BUILD) && !k[9];
      kb       = k[8:0];
      mirror   = kb > 9'd256;
      j        = mirror ? 9'(10'd512 - {1'b0, kb}) : kb;
      src_full = 10'((22'(j) * 22'(ratio(shift))) >> 12);
      zero     = (kb == 9'd256) || (src_full > 10'd255);
      src      = src_full[8:0];
   end

   assign neg_im     = (rd_data[17:0] == 18'h20000) ? 18'h1FFFF : -rd_data[17:0];
   assign wdata      = s1_zero ? '0 : (s1_mirror ? {rd_data[35:18], neg_im} : rd_data);
   assign build_last = s1_vld && (s1_k == 9'd511);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= COLLECT;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         COLLECT: if (fft_done) state_next = DETECT;
         DETECT:  state_next = SNAP;
         SNAP:    state_next = BUILD;
         BUILD:   if (build_last) state_next = COLLECT;
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done        <= 1'b0;
         note_done   <= 1'b0;
         note_name   <= 4'd15;
         note_octave <= 3'd0;
         peak_mag    <= '0;
         peak_bin    <= '0;
         shift       <= '0;
         k           <= '0;
         s1_vld      <= 1'b0;
         s1_k        <= '0;
         s1_mirror   <= 1'b0;
         s1_zero     <= 1'b0;
      end else begin
         done      <= (state == BUILD) && build_last;
         note_done <= (state == DETECT);
         s1_vld    <= issue;
         s1_k      <= kb;
         s1_mirror <= mirror;
         s1_zero   <= zero;
         if (peak_upd) begin
            peak_mag <= mag;
            peak_bin <= fft_address[7:0];
         end
         case (state)
            DETECT: begin
               if (peak_mag < 19'(MIN_MAG)) begin
                  note_name   <= 4'd15;
                  note_octave <= 3'd0;
               end else begin
                  note_name   <= rom_entry[3:0];
                  note_octave <= rom_entry[6:4];
               end
            end
            SNAP: begin
               shift <= shift_calc;
               k     <= '0;
            end
            BUILD: begin
               if (issue) k <= k + 10'd1;
               if (build_last) begin
                  peak_mag <= '0;
                  peak_bin <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (collect_we) in_ram[fft_address] <= fft_data;
      rd_data <= in_ram[src];
   end

   always_ff @(posedge clk) begin
      if (s1_vld) res_ram[s1_k] <= wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_data       <= '0;
         result_read_valid <= 1'b0;
      end else begin
         result_read_valid <= result_read_enable;
         if (result_read_enable) result_data <= res_ram[result_address];
      end
   end

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: frames in, note and result spectrum checked against a
// real-arithmetic model through expected-value queues.
module tb_main_fsm;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        done, note_done;
   logic [3:0]  note_name;
   logic [2:0]  note_octave;
   logic [11:0] scale = 12'hFFF;
   logic        fft_done = 1'b0;
   logic [8:0]  fft_address = '0;
   logic        fft_read_valid = 1'b0;
   logic [35:0] fft_data = '0;
   logic [8:0]  result_address = '0;
   logic        result_read_enable = 1'b0;
   logic [35:0] result_data;
   logic        result_read_valid;

   main_fsm dut (
      .clk(clk), .reset(reset), .done(done), .note_done(note_done),
      .note_name(note_name), .note_octave(note_octave), .scale(scale),
      .fft_done(fft_done), .fft_address(fft_address), .fft_read_valid(fft_read_valid),
      .fft_data(fft_data), .result_address(result_address),
      .result_read_enable(result_read_enable), .result_data(result_data),
      .result_read_valid(result_read_valid)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] NOTE_AS4  = {4'd10, 3'd4};   // bin 5 = 468.75 Hz -> MIDI 70
   localparam logic [6:0] NOTE_NONE = {4'd15, 3'd0};

   int          vectors = 0, miscompares = 0;
   int          done_cnt = 0, note_cnt = 0;
   logic [35:0] frame [512];
   logic [35:0] res_q [$];
   logic [6:0]  note_q [$];
   logic [35:0] last_exp;
   int          pts [16] = '{0, 1, 5, 16, 17, 18, 19, 100, 241, 242, 255, 256, 257, 300, 507, 511};

   always @(negedge clk) begin
      if (done)      done_cnt++;
      if (note_done) note_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // kind 0: peak re=1000 at bin 5; kind 1: flat re=10; kind 2: peak im=-2^17 at bin 5
   task automatic load_frame(input int kind);
      for (int b = 0; b < 512; b++) begin
         if (kind == 1) frame[b] = {18'd10, 18'd0};
         else           frame[b] = {18'(10 + b % 40), 18'((b % 5) - 2)};
      end
      if (kind == 0) frame[5] = {18'd1000, 18'd0};
      if (kind == 2) frame[5] = {18'd0, 18'h20000};
   endtask

   function automatic logic [35:0] model_res(input int a, input int s);
      int          jj, r, srcb;
      logic [35:0] v;
      logic [17:0] nim;
      if (a == 256) return '0;
      jj   = (a <= 256) ? a : 512 - a;
      r    = $rtoi(4096.0 * (2.0 ** (-real'(s) / 12.0)) + 0.5);
      srcb = (jj * r) / 4096;
      v    = (srcb > 255) ? 36'd0 : frame[srcb];
      if (a > 256) begin
         nim = (v[17:0] == 18'h20000) ? 18'h1FFFF : -v[17:0];
         v   = {v[35:18], nim};
      end
      return v;
   endfunction

   task automatic run_frame(input logic [11:0] scl, input logic [6:0] exp_note,
                            input int inject_at, input int abort_at);
      int d0, n0, cyc;
      bit got, aborted;
      d0 = done_cnt; n0 = note_cnt; got = 0; aborted = 0; cyc = 0;
      scale = scl;
      for (int b = 0; b < 512; b++) begin
         @(negedge clk);
         fft_read_valid = 1'b1;
         fft_address    = 9'(b);
         fft_data       = frame[b];
         fft_done       = (b == 511);   // last write coincides with the frame strobe
      end
      note_q.push_back(exp_note);
      @(posedge clk); #1;
      fft_read_valid = 1'b0;
      fft_done       = 1'b0;
      while (!done && cyc < 600 && !aborted) begin
         @(posedge clk); #1;
         cyc++;
         fft_done = (cyc == inject_at);
         if (note_done && note_q.size() > 0) begin
            got = 1;
            check("note", 36'({note_name, note_octave}), 36'(note_q.pop_front()));
         end
         if (abort_at > 0 && cyc == abort_at) begin
            reset   = 1'b1;
            aborted = 1;
         end
      end
      fft_done = 1'b0;
      check("note_done_seen", 36'(got), 36'd1);
      if (!aborted) check("latency_le_520", 36'(cyc <= 520), 36'd1);
      @(negedge clk); @(negedge clk); @(negedge clk);
      check("done_pulses", 36'(done_cnt - d0), aborted ? 36'd0 : 36'd1);
      check("note_done_pulses", 36'(note_cnt - n0), 36'd1);
   endtask

   task automatic read_addr(input int a, input int s, input string tag);
      logic [35:0] e;
      @(negedge clk);
      result_address     = 9'(a);
      result_read_enable = 1'b1;
      res_q.push_back(model_res(a, s));
      @(posedge clk); #1;
      check($sformatf("%s_vld[%0d]", tag, a), 36'(result_read_valid), 36'd1);
      if (res_q.size() > 0) begin
         e        = res_q.pop_front();
         last_exp = e;
         check($sformatf("%s[%0d]", tag, a), result_data, e);
      end
   endtask

   task automatic end_reads(input string tag);
      @(negedge clk);
      result_read_enable = 1'b0;
      @(posedge clk); #1;
      check({tag, "_vld_low"}, 36'(result_read_valid), 36'd0);
      check({tag, "_hold"}, result_data, last_exp);
   endtask

   task automatic read_list(input int s, input string tag);
      foreach (pts[i]) read_addr(pts[i], s, tag);
      end_reads(tag);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_done", 36'(done), 36'd0);
      check("rst_note_done", 36'(note_done), 36'd0);
      check("rst_note_name", 36'(note_name), 36'd15);
      check("rst_note_octave", 36'(note_octave), 36'd0);
      check("rst_result_data", result_data, 36'd0);
      check("rst_result_valid", 36'(result_read_valid), 36'd0);
      reset = 1'b0;

      // Chromatic scale: identity mapping; a stray fft_done during BUILD is ignored
      load_frame(0);
      run_frame(12'hFFF, NOTE_AS4, 100, 0);
      for (int a = 0; a < 256; a++) read_addr(a, 0, "ident");
      read_list(0, "ident");

      // A only: A# snaps one semitone down
      run_frame(12'h200, NOTE_AS4, 0, 0);
      read_list(-1, "a_only");

      // C and B: B is one semitone above A#, C two above
      run_frame(12'h801, NOTE_AS4, 0, 0);
      read_list(1, "c_b");

      // C and G#: two below vs two above, downward wins; im=-2^17 exercises saturation
      load_frame(2);
      run_frame(12'h101, NOTE_AS4, 0, 0);
      read_list(-2, "tie");

      // Below MIN_MAG: no note, identity spectrum
      load_frame(1);
      run_frame(12'hFFF, NOTE_NONE, 0, 0);
      for (int a = 0; a < 256; a++) read_addr(a, 0, "quiet");
      end_reads("quiet");

      // Reset in the middle of BUILD aborts the frame
      load_frame(0);
      run_frame(12'hFFF, NOTE_AS4, 0, 200);
      check("abort_note_name", 36'(note_name), 36'd15);
      check("abort_note_octave", 36'(note_octave), 36'd0);
      check("abort_result_valid", 36'(result_read_valid), 36'd0);
      check("abort_done", 36'(done), 36'd0);
      @(negedge clk);
      reset = 1'b0;
      run_frame(12'h200, NOTE_AS4, 0, 0);
      read_list(-1, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
